// File: rtl/neuron_operand_sequencer_pkg.sv
// Shared definitions for the neuron operand sequencer.
//   - default widths/limits used by the sequencer and its timeout counter
//   - FSM state encoding (also exported on the state_dbg port)
package neuron_operand_sequencer_pkg;

  localparam int NPU_DATA_WIDTH_DEF = 16;
  localparam int MAX_FAN_IN_DEF     = 16;
  localparam int ADDR_WIDTH_DEF     = 4;
  localparam int TIMEOUT_CYCLES_DEF = 255;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_LOAD     = 4'd2,
    ST_ISSUE    = 4'd3,
    ST_WAIT_MAC = 4'd4,
    ST_ACTIVATE = 4'd5,
    ST_WAIT_ACT = 4'd6,
    ST_OUTPUT   = 4'd7,
    ST_ERROR    = 4'd8
  } state_t;

endpackage

// File: rtl/neuron_operand_sequencer_wait_timeout_counter.sv
// wait_timeout_counter: counts cycles spent waiting for a core valid.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clear      : force the count back to zero (held while not waiting)
//   enable     : count this cycle
//   expired    : high in the LIMIT-th consecutive enabled cycle
module wait_timeout_counter #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt;

  // First waiting cycle sees cnt == 0, so the LIMIT-th one sees LAST.
  assign expired = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/neuron_operand_sequencer.sv
// neuron_operand_sequencer: sequences one neuron evaluation through the
// math calculation core. Fetches fan_in operand pairs from the layer
// buffers, issues one calculator_start per pair, then one sigmoid_start,
// and presents the activated value on a valid/ready result port.
// Ports:
//   clk, reset                         : clock, synchronous active-high reset
//   neuron_start, fan_in               : evaluation request and pair count
//   neuron_busy, cfg_error, timeout_error : status
//   rd_en, rd_addr, input_rd_data, weight_rd_data : operand buffer read port
//   calculator_start, sigmoid_start, input_value, weight_value : core requests
//   calculator_valid, sigmoid_valid, calculation_result       : core responses
//   result_valid, result_data, result_ready                   : result port
//   state_dbg                          : current FSM state
//
// Result handshake: result_valid/result_data are held stable from the first
// OUTPUT cycle until a cycle in which result_ready is high; that cycle is the
// transfer, and result_valid drops on the following cycle.
module neuron_operand_sequencer
  import neuron_operand_sequencer_pkg::*;
#(
  parameter int NPU_DATA_WIDTH = NPU_DATA_WIDTH_DEF,
  parameter int MAX_FAN_IN     = MAX_FAN_IN_DEF,
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      neuron_start,
  input  logic [ADDR_WIDTH:0]       fan_in,
  output logic                      neuron_busy,
  output logic                      cfg_error,
  output logic                      timeout_error,
  output logic                      rd_en,
  output logic [ADDR_WIDTH-1:0]     rd_addr,
  input  logic [NPU_DATA_WIDTH-1:0] input_rd_data,
  input  logic [NPU_DATA_WIDTH-1:0] weight_rd_data,
  output logic                      calculator_start,
  output logic                      sigmoid_start,
  output logic [NPU_DATA_WIDTH-1:0] input_value,
  output logic [NPU_DATA_WIDTH-1:0] weight_value,
  input  logic                      calculator_valid,
  input  logic                      sigmoid_valid,
  input  logic [NPU_DATA_WIDTH-1:0] calculation_result,
  output logic                      result_valid,
  output logic [NPU_DATA_WIDTH-1:0] result_data,
  input  logic                      result_ready,
  output state_t                    state_dbg
);

  localparam logic [ADDR_WIDTH:0] FAN_MAX = (ADDR_WIDTH + 1)'(MAX_FAN_IN);
  localparam logic [ADDR_WIDTH:0] FAN_ONE = (ADDR_WIDTH + 1)'(1);

  state_t              state;
  state_t              state_next;
  logic [ADDR_WIDTH:0] fan_in_q;
  logic [ADDR_WIDTH:0] k;
  logic                fan_in_ok;
  logic                start_accept;
  logic                start_reject;
  logic                last_pair;
  logic                in_wait;
  logic                wait_expired;

  assign fan_in_ok    = (fan_in != '0) && (fan_in <= FAN_MAX);
  assign start_accept = (state == ST_IDLE) && neuron_start && fan_in_ok;
  assign start_reject = (state == ST_IDLE) && neuron_start && !fan_in_ok;
  assign last_pair    = (k == fan_in_q - FAN_ONE);
  assign in_wait      = (state == ST_WAIT_MAC) || (state == ST_WAIT_ACT);

  // Every path into a WAIT state passes through a non-wait state, so holding
  // the counter clear outside the WAIT states clears it on each entry.
  wait_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wait_timeout_counter (
    .clk     (clk),
    .reset   (reset),
    .clear   (!in_wait),
    .enable  (in_wait),
    .expired (wait_expired)
  );

  always_comb begin
    state_next       = state;
    rd_en            = 1'b0;
    rd_addr          = '0;
    calculator_start = 1'b0;
    sigmoid_start    = 1'b0;
    result_valid     = 1'b0;
    neuron_busy      = (state != ST_IDLE);
    state_dbg        = state;
    unique case (state)
      ST_IDLE: begin
        if (start_accept) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        rd_en      = 1'b1;
        rd_addr    = k[ADDR_WIDTH-1:0];
        state_next = ST_LOAD;
      end
      ST_LOAD: begin
        state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        calculator_start = 1'b1;
        state_next       = ST_WAIT_MAC;
      end
      ST_WAIT_MAC: begin
        if (calculator_valid) begin
          state_next = last_pair ? ST_ACTIVATE : ST_FETCH;
        end else if (wait_expired) begin
          state_next = ST_ERROR;
        end
      end
      ST_ACTIVATE: begin
        sigmoid_start = 1'b1;
        state_next    = ST_WAIT_ACT;
      end
      ST_WAIT_ACT: begin
        if (sigmoid_valid) begin
          state_next = ST_OUTPUT;
        end else if (wait_expired) begin
          state_next = ST_ERROR;
        end
      end
      ST_OUTPUT: begin
        result_valid = 1'b1;
        if (result_ready) state_next = ST_IDLE;
      end
      ST_ERROR: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      fan_in_q      <= '0;
      k             <= '0;
      input_value   <= '0;
      weight_value  <= '0;
      result_data   <= '0;
      cfg_error     <= 1'b0;
      timeout_error <= 1'b0;
    end else begin
      state     <= state_next;
      cfg_error <= start_reject;

      if (start_accept) begin
        fan_in_q      <= fan_in;
        k             <= '0;
        timeout_error <= 1'b0;
      end else if (state == ST_ERROR) begin
        timeout_error <= 1'b1;
      end

      if ((state == ST_WAIT_MAC) && calculator_valid && !last_pair) begin
        k <= k + FAN_ONE;
      end

      // Buffer data arrives the cycle after rd_en, i.e. during LOAD.
      if (state == ST_LOAD) begin
        input_value  <= input_rd_data;
        weight_value <= weight_rd_data;
      end

      if ((state == ST_WAIT_ACT) && sigmoid_valid) begin
        result_data <= calculation_result;
      end
    end
  end

endmodule

// File: tb/tb_neuron_operand_sequencer.sv
// Bench for neuron_operand_sequencer: operand buffer model, a core model with
// programmable MAC/activation latency, and per-scenario test tasks.
module tb_neuron_operand_sequencer;
  import neuron_operand_sequencer_pkg::*;

  localparam int DW   = 16;
  localparam int AW   = 4;
  localparam int MAXF = 16;
  localparam int TMO  = 255;

  logic          clk;
  logic          reset;
  logic          neuron_start;
  logic [AW:0]   fan_in;
  logic          neuron_busy;
  logic          cfg_error;
  logic          timeout_error;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] input_rd_data;
  logic [DW-1:0] weight_rd_data;
  logic          calculator_start;
  logic          sigmoid_start;
  logic [DW-1:0] input_value;
  logic [DW-1:0] weight_value;
  logic          calculator_valid;
  logic          sigmoid_valid;
  logic [DW-1:0] calculation_result;
  logic          result_valid;
  logic [DW-1:0] result_data;
  logic          result_ready;
  state_t        state_dbg;

  neuron_operand_sequencer #(
    .NPU_DATA_WIDTH (DW),
    .MAX_FAN_IN     (MAXF),
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .neuron_start       (neuron_start),
    .fan_in             (fan_in),
    .neuron_busy        (neuron_busy),
    .cfg_error          (cfg_error),
    .timeout_error      (timeout_error),
    .rd_en              (rd_en),
    .rd_addr            (rd_addr),
    .input_rd_data      (input_rd_data),
    .weight_rd_data     (weight_rd_data),
    .calculator_start   (calculator_start),
    .sigmoid_start      (sigmoid_start),
    .input_value        (input_value),
    .weight_value       (weight_value),
    .calculator_valid   (calculator_valid),
    .sigmoid_valid      (sigmoid_valid),
    .calculation_result (calculation_result),
    .result_valid       (result_valid),
    .result_data        (result_data),
    .result_ready       (result_ready),
    .state_dbg          (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end, time %0t required earlier", $time);
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  // ---------------- operand buffer model ----------------
  logic [DW-1:0] in_mem [16];
  logic [DW-1:0] wt_mem [16];

  always @(posedge clk) begin
    if (rd_en) begin
      input_rd_data  <= in_mem[rd_addr];
      weight_rd_data <= wt_mem[rd_addr];
    end else begin
      input_rd_data  <= DW'($urandom);
      weight_rd_data <= DW'($urandom);
    end
  end

  // ---------------- core model ----------------
  int            cyc      = 0;
  int            mac_lat  = 2;
  int            act_lat  = 2;
  bit            mac_mute = 1'b0;
  logic [DW-1:0] sig_result = '0;
  int            mac_due  = -100;
  int            act_due  = -100;
  int            calc_cnt = 0;
  int            sig_cnt  = 0;
  int            rd_cnt   = 0;
  logic          core_calc_valid  = 1'b0;
  logic          stray_calc_valid = 1'b0;
  logic [2*DW-1:0] obs_q [$];
  logic [2*DW-1:0] exp_q [$];

  assign calculator_valid = core_calc_valid | stray_calc_valid;

  initial begin
    sigmoid_valid      = 1'b0;
    calculation_result = '0;
  end

  // cyc numbers the cycle that just ended; valid goes high LAT cycles after
  // the cycle that carried the start pulse.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en) rd_cnt <= rd_cnt + 1;
    if (calculator_start) begin
      calc_cnt <= calc_cnt + 1;
      obs_q.push_back({input_value, weight_value});
      mac_due <= cyc + mac_lat;
    end
    if (sigmoid_start) begin
      sig_cnt <= sig_cnt + 1;
      act_due <= cyc + act_lat;
    end
    core_calc_valid <= !mac_mute &&
                       ((cyc + 1 == mac_due) || (calculator_start && mac_lat == 1));
    if ((cyc + 1 == act_due) || (sigmoid_start && act_lat == 1)) begin
      sigmoid_valid      <= 1'b1;
      calculation_result <= sig_result;
    end else begin
      sigmoid_valid      <= 1'b0;
      calculation_result <= DW'($urandom);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_random_mems();
    for (int i = 0; i < 16; i++) begin
      in_mem[i] = DW'($urandom);
      wt_mem[i] = DW'($urandom);
    end
  endtask

  task automatic build_expected(input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back({in_mem[i], wt_mem[i]});
  endtask

  // Called at a negedge. Issues a start, runs the neuron until busy drops
  // and returns at the first idle negedge (where a new start may be issued).
  task automatic drive_neuron(input int n, input int rdy_delay, input bit ready_early,
                              input bit poke, output int busy_cyc, output bit rd_first,
                              output bit te_first, output bit res_stable,
                              output logic [DW-1:0] res_seen, output bit timed_out);
    int out_cyc = 0;
    int guard   = 0;
    bit prev_sig = 1'b0;
    bit poked    = 1'b0;
    obs_q.delete();
    busy_cyc = 0; res_stable = 1'b1; res_seen = '0; timed_out = 1'b0;
    neuron_start = 1'b1;
    fan_in       = (AW + 1)'(n);
    result_ready = ready_early;
    @(negedge clk);
    neuron_start = 1'b0;
    rd_first = rd_en;
    te_first = timeout_error;
    while (neuron_busy && guard < 20000) begin
      busy_cyc++;
      guard++;
      stray_calc_valid = 1'b0;
      neuron_start     = 1'b0;
      if (result_valid) begin
        if (out_cyc == 0) res_seen = result_data;
        else if (result_data !== res_seen) res_stable = 1'b0;
        out_cyc++;
        if (poke && out_cyc == 1) stray_calc_valid = 1'b1;
        if (!ready_early) result_ready = (out_cyc > rdy_delay);
      end
      if (poke && prev_sig && !poked) begin
        neuron_start = 1'b1;
        fan_in       = (AW + 1)'(3);
        poked        = 1'b1;
      end
      prev_sig = sigmoid_start;
      @(negedge clk);
    end
    stray_calc_valid = 1'b0;
    neuron_start     = 1'b0;
    result_ready     = 1'b0;
    if (guard >= 20000) timed_out = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({neuron_busy, cfg_error, timeout_error, rd_en, rd_addr, calculator_start, sigmoid_start,
         input_value, weight_value, result_valid, result_data} !== 59'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b cfg=%b tmo=%b rd=%b addr=%h cs=%b ss=%b iv=%h wv=%h rv=%b rd=%h, required all 0",
               neuron_busy, cfg_error, timeout_error, rd_en, rd_addr, calculator_start,
               sigmoid_start, input_value, weight_value, result_valid, result_data);
    end
    checks++;
    if (state_dbg !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d required %0d", state_dbg, ST_IDLE);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (neuron_busy !== 1'b0 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got busy=%b rv=%b required 0 0", neuron_busy, result_valid);
    end
  endtask

  task automatic test_directed_vector();
    int busy_cyc, c0, s0, exp_busy;
    bit rd_first, te_first, stable, tmo;
    logic [DW-1:0] res;
    for (int i = 0; i < 16; i++) begin
      in_mem[i] = DW'(16'h0100 * (2 * i + 1));
      wt_mem[i] = DW'(16'h0100 * (2 * i + 2));
    end
    build_expected(3);
    mac_lat = 2; act_lat = 2; sig_result = 16'h00B0;
    c0 = calc_cnt; s0 = sig_cnt;
    drive_neuron(3, 5, 1'b0, 1'b0, busy_cyc, rd_first, te_first, stable, res, tmo);
    exp_busy = 3 * (3 + 2) + 1 + 2 + 5 + 1;
    checks++;
    if (tmo) begin errors++; $display("FAIL directed_done: run did not finish, required finish"); end
    checks++;
    if (rd_first !== 1'b1) begin errors++; $display("FAIL directed_rd_en_cycle1: got %b required 1", rd_first); end
    checks++;
    if (calc_cnt - c0 != 3) begin errors++; $display("FAIL directed_calc_starts: got %0d required 3", calc_cnt - c0); end
    checks++;
    if (sig_cnt - s0 != 1) begin errors++; $display("FAIL directed_sig_starts: got %0d required 1", sig_cnt - s0); end
    checks++;
    if (obs_q.size() != 3) begin errors++; $display("FAIL directed_op_count: got %0d required 3", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 3; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL directed_operand[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (res !== 16'h00B0) begin errors++; $display("FAIL directed_result: got %h required 00b0", res); end
    checks++;
    if (!stable) begin errors++; $display("FAIL directed_result_stable: got unstable required stable"); end
    checks++;
    if (busy_cyc != exp_busy) begin errors++; $display("FAIL directed_busy_cycles: got %0d required %0d", busy_cyc, exp_busy); end
    checks++;
    if (result_data !== 16'h00B0 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL directed_result_hold: got data=%h rv=%b required 00b0 0", result_data, result_valid);
    end
  endtask

  task automatic test_cfg_error();
    int r0;
    int bad [2] = '{0, 17};
    r0 = rd_cnt;
    foreach (bad[j]) begin
      neuron_start = 1'b1;
      fan_in = (AW + 1)'(bad[j]);
      @(negedge clk);
      neuron_start = 1'b0;
      checks++;
      if (cfg_error !== 1'b1 || neuron_busy !== 1'b0 || rd_en !== 1'b0) begin
        errors++;
        $display("FAIL cfg_error_pulse fan_in=%0d: got cfg=%b busy=%b rd=%b required 1 0 0",
                 bad[j], cfg_error, neuron_busy, rd_en);
      end
      @(negedge clk);
      checks++;
      if (cfg_error !== 1'b0 || neuron_busy !== 1'b0) begin
        errors++;
        $display("FAIL cfg_error_one_cycle fan_in=%0d: got cfg=%b busy=%b required 0 0",
                 bad[j], cfg_error, neuron_busy);
      end
    end
    checks++;
    if (rd_cnt != r0) begin errors++; $display("FAIL cfg_error_no_read: got %0d reads required 0", rd_cnt - r0); end
  endtask

  task automatic test_random_neurons(input int iters, input bit force_max);
    int busy_cyc, c0, s0, exp_busy, n, rdy;
    bit rd_first, te_first, stable, tmo, early;
    logic [DW-1:0] res;
    for (int it = 0; it < iters; it++) begin
      n = force_max ? MAXF : $urandom_range(1, MAXF);
      mac_lat = $urandom_range(1, 4);
      act_lat = $urandom_range(1, 4);
      rdy     = $urandom_range(0, 3);
      early   = ($urandom_range(0, 3) == 0);
      sig_result = DW'($urandom);
      load_random_mems();
      build_expected(n);
      c0 = calc_cnt; s0 = sig_cnt;
      drive_neuron(n, rdy, early, 1'b0, busy_cyc, rd_first, te_first, stable, res, tmo);
      exp_busy = n * (3 + mac_lat) + 1 + act_lat + (early ? 0 : rdy) + 1;
      checks++;
      if (tmo || rd_first !== 1'b1) begin
        errors++;
        $display("FAIL rand_accept n=%0d: got timeout=%b rd_first=%b required 0 1", n, tmo, rd_first);
      end
      checks++;
      if (calc_cnt - c0 != n || sig_cnt - s0 != 1) begin
        errors++;
        $display("FAIL rand_pulses n=%0d: got calc=%0d sig=%0d required %0d 1", n, calc_cnt - c0, sig_cnt - s0, n);
      end
      for (int i = 0; i < n; i++) begin
        checks++;
        if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rand_operand[%0d] n=%0d: got %h required %h", i, n,
                   (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
        end
      end
      checks++;
      if (res !== sig_result || !stable) begin
        errors++;
        $display("FAIL rand_result n=%0d: got %h stable=%b required %h stable=1", n, res, stable, sig_result);
      end
      checks++;
      if (busy_cyc != exp_busy) begin
        errors++;
        $display("FAIL rand_busy_cycles n=%0d: got %0d required %0d", n, busy_cyc, exp_busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    int busy_cyc, exp_busy;
    bit rd_first, te_first, stable, tmo;
    logic [DW-1:0] res;
    mac_lat = 1; act_lat = 1;
    for (int r = 0; r < 3; r++) begin
      load_random_mems();
      sig_result = DW'($urandom);
      drive_neuron(r + 1, 0, 1'b0, 1'b0, busy_cyc, rd_first, te_first, stable, res, tmo);
      exp_busy = (r + 1) * 4 + 1 + 1 + 1;
      checks++;
      if (rd_first !== 1'b1 || res !== sig_result || busy_cyc != exp_busy) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got rd_first=%b res=%h busy=%0d required 1 %h %0d",
                 r, rd_first, res, busy_cyc, sig_result, exp_busy);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int busy_cyc, c0, s0, r0, exp_busy;
    bit rd_first, te_first, stable, tmo;
    bit stayed_idle = 1'b1;
    logic [DW-1:0] res;
    mac_lat = 2; act_lat = 3; sig_result = 16'h5A3C;
    load_random_mems();
    c0 = calc_cnt; s0 = sig_cnt;
    drive_neuron(2, 3, 1'b0, 1'b1, busy_cyc, rd_first, te_first, stable, res, tmo);
    exp_busy = 2 * (3 + 2) + 1 + 3 + 3 + 1;
    checks++;
    if (calc_cnt - c0 != 2 || sig_cnt - s0 != 1) begin
      errors++;
      $display("FAIL ignore_pulses: got calc=%0d sig=%0d required 2 1", calc_cnt - c0, sig_cnt - s0);
    end
    checks++;
    if (res !== 16'h5A3C || !stable || busy_cyc != exp_busy) begin
      errors++;
      $display("FAIL ignore_result: got %h stable=%b busy=%0d required 5a3c 1 %0d", res, stable, busy_cyc, exp_busy);
    end
    r0 = rd_cnt;
    repeat (5) begin
      if (neuron_busy !== 1'b0) stayed_idle = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (!stayed_idle || rd_cnt != r0) begin
      errors++;
      $display("FAIL ignore_no_queued_start: got idle=%b reads=%0d required 1 0", stayed_idle, rd_cnt - r0);
    end
  endtask

  task automatic test_timeout();
    int busy_cyc, c0, s0, exp_busy;
    bit rd_first, te_first, stable, tmo;
    bit sticky = 1'b1;
    logic [DW-1:0] res;
    mac_lat = 2; act_lat = 2; mac_mute = 1'b1;
    load_random_mems();
    c0 = calc_cnt; s0 = sig_cnt;
    drive_neuron(2, 0, 1'b0, 1'b0, busy_cyc, rd_first, te_first, stable, res, tmo);
    exp_busy = 3 + TMO + 1;
    checks++;
    if (busy_cyc != exp_busy) begin errors++; $display("FAIL timeout_busy_cycles: got %0d required %0d", busy_cyc, exp_busy); end
    checks++;
    if (calc_cnt - c0 != 1 || sig_cnt - s0 != 0) begin
      errors++;
      $display("FAIL timeout_pulses: got calc=%0d sig=%0d required 1 0", calc_cnt - c0, sig_cnt - s0);
    end
    repeat (4) begin
      if (timeout_error !== 1'b1 || result_valid !== 1'b0) sticky = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (!sticky) begin errors++; $display("FAIL timeout_sticky: got not sticky required timeout_error=1 no result"); end
    mac_mute = 1'b0;
    sig_result = 16'h1234;
    drive_neuron(1, 1, 1'b0, 1'b0, busy_cyc, rd_first, te_first, stable, res, tmo);
    checks++;
    if (te_first !== 1'b0 || timeout_error !== 1'b0) begin
      errors++;
      $display("FAIL timeout_cleared_by_start: got %b/%b required 0/0", te_first, timeout_error);
    end
    checks++;
    if (res !== 16'h1234) begin errors++; $display("FAIL timeout_recovery_result: got %h required 1234", res); end
  endtask

  task automatic test_reset_mid();
    int busy_cyc, c0, guard, exp_busy;
    bit rd_first, te_first, stable, tmo;
    logic [DW-1:0] res;
    mac_lat = 6; act_lat = 2;
    load_random_mems();
    c0 = calc_cnt;
    neuron_start = 1'b1;
    fan_in = (AW + 1)'(4);
    @(negedge clk);
    neuron_start = 1'b0;
    guard = 0;
    while (calc_cnt - c0 < 2 && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    checks++;
    if (guard >= 200) begin errors++; $display("FAIL reset_mid_reach_pair2: got no second start required one"); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({neuron_busy, cfg_error, timeout_error, rd_en, rd_addr, calculator_start, sigmoid_start,
         input_value, weight_value, result_valid, result_data} !== 59'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got busy=%b rd=%b iv=%h wv=%h rv=%b rdat=%h, required all 0",
               neuron_busy, rd_en, input_value, weight_value, result_valid, result_data);
    end
    reset = 1'b0;
    repeat (10) @(negedge clk);
    mac_lat = 2;
    sig_result = 16'hBEEF;
    build_expected(1);
    drive_neuron(1, 0, 1'b1, 1'b0, busy_cyc, rd_first, te_first, stable, res, tmo);
    exp_busy = 1 * (3 + 2) + 1 + 2 + 1;
    checks++;
    if (res !== 16'hBEEF || busy_cyc != exp_busy || obs_q.size() != 1) begin
      errors++;
      $display("FAIL reset_mid_fresh_run: got res=%h busy=%0d ops=%0d required beef %0d 1",
               res, busy_cyc, obs_q.size(), exp_busy);
    end else begin
      checks++;
      if (obs_q[0] !== exp_q[0]) begin
        errors++;
        $display("FAIL reset_mid_operand: got %h required %h", obs_q[0], exp_q[0]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset            = 1'b1;
    neuron_start     = 1'b0;
    fan_in           = '0;
    result_ready     = 1'b0;
    test_reset();
    test_directed_vector();
    test_cfg_error();
    test_random_neurons(1, 1'b1);
    test_random_neurons(8, 1'b0);
    test_back_to_back();
    test_busy_ignore();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
